// File: rtl/fft_frame_loader.sv
// Front end of the FFT core. It windows real samples and writes N complex words into RAM0 at
// bit-reversed addresses, then starts the FFT and holds off the next frame until done rises.
module fft_frame_loader #(
    parameter int width     = 16,
    parameter int N_2       = 5,
    parameter int WINDOW_EN = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [width-6:0]     s_data,
    input  logic                 fft_done,
    output logic                 load_we,
    output logic [N_2-1:0]       load_adr,
    output logic [2*width-1:0]   load_wd,
    output logic                 fft_start,
    output logic                 busy
);
    localparam int N = 1 << N_2;

    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, START, WAIT} state_t;

    state_t           state, state_nxt;
    logic [N_2-1:0]   idx, idx_nxt;
    logic             done_q;
    logic             xfer;
    logic [width-1:0] x, re;

    // Hann coefficient in unsigned Q1.(width-1); peak at N/2 is 2**(width-1)-1
    function automatic logic [width-1:0] hann_val(input int k);
        real c, v;
        c = $cos(2.0 * 3.141592653589793 * real'(k) / real'(N));
        v = real'((1 << (width-1)) - 1) * (1.0 - c) / 2.0;
        return width'($rtoi(v + 0.5));
    endfunction

    function automatic logic [N_2-1:0] bitrev(input logic [N_2-1:0] i);
        logic [N_2-1:0] r;
        for (int k = 0; k < N_2; k++) r[k] = i[N_2-1-k];
        return r;
    endfunction

    assign x = {{5{s_data[width-6]}}, s_data};

    generate
        if (WINDOW_EN != 0) begin : g_win
            logic [width-1:0] hann_lut [N];
            for (genvar k = 0; k < N; k++) begin : g_lut
                assign hann_lut[k] = hann_val(k);
            end
            // Full-width signed product, then arithmetic shift: rounds toward -inf
            assign re = width'(($signed({{width{x[width-1]}}, x}) *
                                $signed({{width{1'b0}}, hann_lut[idx]})) >>> (width-1));
        end else begin : g_bypass
            assign re = x;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            idx    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            done_q <= fft_done;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        s_ready   = 1'b0;
        fft_start = 1'b0;
        busy      = 1'b0;
        xfer      = 1'b0;
        case (state)
            IDLE:  state_nxt = LOAD;
            LOAD: begin
                s_ready = 1'b1;
                xfer    = s_valid;
                busy    = (idx != '0) || s_valid;
                if (s_valid) begin
                    idx_nxt = idx + 1'b1;
                    if (&idx) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy      = 1'b1;
                state_nxt = START;
            end
            START: begin
                busy      = 1'b1;
                fft_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                // Only a fresh edge counts; a level left high from the previous frame is ignored
                if (fft_done && !done_q) begin
                    state_nxt = LOAD;
                    idx_nxt   = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            load_we  <= 1'b0;
            load_adr <= '0;
            load_wd  <= '0;
        end else begin
            load_we <= xfer;
            if (xfer) begin
                load_adr <= bitrev(idx);
                load_wd  <= {re, {width{1'b0}}};
            end
        end
    end
endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed bench for fft_frame_loader: bypass and windowed instances driven from shared stimulus.
module tb_fft_frame_loader;
    localparam int N = 32;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        fft_done = 1'b0;
    logic [10:0] s_data = '0;

    logic        s_ready0, load_we0, fft_start0, busy0;
    logic [4:0]  load_adr0;
    logic [31:0] load_wd0;
    logic        s_ready1, load_we1, fft_start1, busy1;
    logic [4:0]  load_adr1;
    logic [31:0] load_wd1;

    fft_frame_loader #(.width(16), .N_2(5), .WINDOW_EN(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready0),
        .s_data(s_data), .fft_done(fft_done), .load_we(load_we0), .load_adr(load_adr0),
        .load_wd(load_wd0), .fft_start(fft_start0), .busy(busy0));

    fft_frame_loader #(.width(16), .N_2(5), .WINDOW_EN(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready1),
        .s_data(s_data), .fft_done(fft_done), .load_we(load_we1), .load_adr(load_adr1),
        .load_wd(load_wd1), .fft_start(fft_start1), .busy(busy1));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int c; logic [4:0] adr; logic [31:0] wd;} wr_t;
    wr_t q0[$];
    wr_t q1[$];
    int  st0[$];
    int  xc[N];
    int  total = 0;
    int  bad = 0;

    always @(negedge clk) begin
        if (load_we0) q0.push_back(wr_t'{cyc, load_adr0, load_wd0});
        if (load_we1) q1.push_back(wr_t'{cyc, load_adr1, load_wd1});
        if (fft_start0) st0.push_back(cyc);
    end

    function automatic logic [4:0] brev(input int i);
        logic [4:0] a, r;
        a = 5'(i);
        for (int k = 0; k < 5; k++) r[k] = a[4-k];
        return r;
    endfunction

    function automatic int hann(input int k);
        real c, v;
        c = $cos(2.0 * 3.141592653589793 * real'(k) / real'(N));
        v = 32767.0 * (1.0 - c) / 2.0;
        return $rtoi(v + 0.5);
    endfunction

    function automatic logic [15:0] win(input int xv, input int k);
        longint p;
        p = longint'(xv) * longint'(hann(k));
        return 16'(p >>> 15);
    endfunction

    task automatic drive(input logic v, input logic [10:0] d, output logic x, output int c);
        @(negedge clk);
        s_valid = v;
        s_data  = d;
        x = v & s_ready0;
        c = cyc;
    endtask

    task automatic idle(input int n);
        logic x;
        int c;
        repeat (n) drive(1'b0, 11'h0, x, c);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n  = 1'b0;
        s_valid  = 1'b0;
        fft_done = 1'b0;
        s_data   = '0;
        repeat (2) @(negedge clk);
        q0.delete(); q1.delete(); st0.delete();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Sends one full frame of data base+step*i; records each transfer's cycle in xc
    task automatic load_frame(input int base, input int step, input logic throttle);
        int n, it, c;
        logic x, v;
        n = 0; it = 0;
        while (n < N && it < 300) begin
            v = throttle ? ~it[0] : 1'b1;
            drive(v, 11'(base + step * n), x, c);
            if (x) begin xc[n] = c; n++; end
            it++;
        end
        drive(1'b0, 11'h0, x, c);
        if (n < N) begin
            total++; bad++;
            $display("FAIL load_frame timeout: transfers=%0d need=%0d", n, N);
        end
    endtask

    task automatic test_reset();
        logic x;
        int c, n;
        do_reset();
        total++; if (s_ready0 !== 1'b0) begin bad++; $display("FAIL rst_idle_ready: got %b exp 0", s_ready0); end
        n = 0;
        for (int i = 0; i < 20 && n < 7; i++) begin
            drive(1'b1, 11'(i + 1), x, c);
            if (i == 0) begin
                total++; if (x !== 1'b1) begin bad++; $display("FAIL rst_ready_after_idle: got %b exp 1", x); end
            end
            if (x) n++;
        end
        idle(1);
        total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL busy_mid_frame: got %b exp 1", busy0); end
        #1 reset_n = 1'b0;
        #1;
        total++; if (busy0 !== 1'b0 || s_ready0 !== 1'b0 || load_we0 !== 1'b0 || fft_start0 !== 1'b0)
            begin bad++; $display("FAIL rst_outputs: busy=%b ready=%b we=%b start=%b exp 0000", busy0, s_ready0, load_we0, fft_start0); end
        total++; if (load_adr0 !== 5'd0 || load_wd0 !== 32'd0)
            begin bad++; $display("FAIL rst_adr_wd: adr=%0d wd=%h exp 0/0", load_adr0, load_wd0); end
        repeat (2) @(negedge clk);
        q0.delete();
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        total++; if (s_ready0 !== 1'b0) begin bad++; $display("FAIL rst_release_ready: got %b exp 0", s_ready0); end
        drive(1'b1, 11'd9, x, c);
        total++; if (x !== 1'b1) begin bad++; $display("FAIL rst_release_ready2: got %b exp 1", x); end
        idle(2);
        total++; if (q0.size() != 1) begin bad++; $display("FAIL rst_first_write_count: got %0d exp 1", q0.size()); end
        else if (q0[0].adr !== 5'd0 || q0[0].wd !== {16'd9, 16'd0})
            begin total++; bad++; $display("FAIL rst_first_write: adr=%0d wd=%h exp 0/00090000", q0[0].adr, q0[0].wd); end
    endtask

    task automatic test_bypass();
        do_reset();
        load_frame(0, 1, 1'b0);
        idle(4);
        total++; if (q0.size() != N) begin bad++; $display("FAIL byp_count: got %0d exp %0d", q0.size(), N); end
        else begin
            for (int i = 0; i < N; i++) begin
                total++;
                if (q0[i].adr !== brev(i) || q0[i].wd !== {16'(i), 16'h0} || q0[i].c != xc[i] + 1) begin
                    bad++;
                    $display("FAIL byp_write[%0d]: adr=%0d wd=%h cyc=%0d exp adr=%0d wd=%h cyc=%0d",
                             i, q0[i].adr, q0[i].wd, q0[i].c, brev(i), {16'(i), 16'h0}, xc[i] + 1);
                end
            end
            total++; if (q0[1].adr !== 5'd16 || q0[3].adr !== 5'd24 || q0[31].adr !== 5'd31)
                begin bad++; $display("FAIL byp_adr_order: %0d %0d %0d exp 16 24 31", q0[1].adr, q0[3].adr, q0[31].adr); end
        end
        total++; if (st0.size() != 1) begin bad++; $display("FAIL byp_start_count: got %0d exp 1", st0.size()); end
        else begin
            total++; if (st0[0] != xc[N-1] + 2) begin bad++; $display("FAIL byp_start_cyc: got %0d exp %0d", st0[0], xc[N-1] + 2); end
        end
        total++; if (s_ready0 !== 1'b0 || busy0 !== 1'b1)
            begin bad++; $display("FAIL byp_wait: ready=%b busy=%b exp 0/1", s_ready0, busy0); end
    endtask

    task automatic test_window();
        do_reset();
        load_frame(1023, 0, 1'b0);
        idle(3);
        total++; if (q1.size() != N) begin bad++; $display("FAIL win_count: got %0d exp %0d", q1.size(), N); end
        else begin
            for (int i = 0; i < N; i++) begin
                total++;
                if (q1[i].adr !== brev(i) || q1[i].wd !== {win(1023, i), 16'h0}) begin
                    bad++;
                    $display("FAIL win_pos[%0d]: adr=%0d wd=%h exp adr=%0d wd=%h", i, q1[i].adr, q1[i].wd, brev(i), {win(1023, i), 16'h0});
                end
            end
            total++; if (q1[0].wd !== 32'h0 || q1[16].wd !== {16'd1022, 16'h0})
                begin bad++; $display("FAIL win_ends: k0=%h k16=%h exp 00000000 03fe0000", q1[0].wd, q1[16].wd); end
        end
        fft_done = 1'b1;
        idle(1);
        fft_done = 1'b0;
        q1.delete();
        load_frame(-1024, 0, 1'b0);
        idle(3);
        total++; if (q1.size() != N) begin bad++; $display("FAIL win_neg_count: got %0d exp %0d", q1.size(), N); end
        else begin
            for (int i = 0; i < N; i++) begin
                total++;
                if (q1[i].wd !== {win(-1024, i), 16'h0} || $signed(q1[i].wd[31:16]) > 0) begin
                    bad++;
                    $display("FAIL win_neg[%0d]: wd=%h exp %h", i, q1[i].wd, {win(-1024, i), 16'h0});
                end
            end
            total++; if (q1[16].wd !== {16'hFC00, 16'h0})
                begin bad++; $display("FAIL win_neg_peak: got %h exp fc000000", q1[16].wd); end
        end
    endtask

    task automatic test_throttle();
        do_reset();
        load_frame(100, 1, 1'b1);
        idle(3);
        total++; if (q0.size() != N) begin bad++; $display("FAIL thr_count: got %0d exp %0d", q0.size(), N); end
        else begin
            for (int i = 0; i < N; i++) begin
                total++;
                if (q0[i].c != xc[i] + 1 || q0[i].adr !== brev(i) || q0[i].wd !== {16'(100 + i), 16'h0}) begin
                    bad++;
                    $display("FAIL thr_write[%0d]: cyc=%0d adr=%0d wd=%h exp cyc=%0d adr=%0d wd=%h",
                             i, q0[i].c, q0[i].adr, q0[i].wd, xc[i] + 1, brev(i), {16'(100 + i), 16'h0});
                end
            end
        end
    endtask

    task automatic test_done_edge();
        do_reset();
        fft_done = 1'b1;
        load_frame(0, 1, 1'b0);
        idle(6);
        total++; if (s_ready0 !== 1'b0 || busy0 !== 1'b1 || st0.size() != 1)
            begin bad++; $display("FAIL done_held: ready=%b busy=%b starts=%0d exp 0/1/1", s_ready0, busy0, st0.size()); end
        fft_done = 1'b0;
        idle(1);
        total++; if (s_ready0 !== 1'b0) begin bad++; $display("FAIL done_low: ready=%b exp 0", s_ready0); end
        fft_done = 1'b1;
        idle(1);
        total++; if (s_ready0 !== 1'b1 || busy0 !== 1'b0)
            begin bad++; $display("FAIL done_rise: ready=%b busy=%b exp 1/0", s_ready0, busy0); end
        fft_done = 1'b0;
    endtask

    task automatic test_wait_ignore();
        logic x;
        int c;
        do_reset();
        load_frame(0, 1, 1'b0);
        idle(3);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 11'd5, x, c);
            total++; if (x !== 1'b0) begin bad++; $display("FAIL wait_consumed[%0d]: got %b exp 0", i, x); end
        end
        total++; if (q0.size() != N) begin bad++; $display("FAIL wait_no_write: got %0d exp %0d", q0.size(), N); end
        fft_done = 1'b1;
        drive(1'b1, 11'd5, x, c);
        total++; if (x !== 1'b1 || busy0 !== 1'b1)
            begin bad++; $display("FAIL wait_reenter: xfer=%b busy=%b exp 1/1", x, busy0); end
        fft_done = 1'b0;
        idle(2);
        total++; if (q0.size() != N + 1) begin bad++; $display("FAIL wait_first_count: got %0d exp %0d", q0.size(), N + 1); end
        else begin
            total++; if (q0[N].adr !== 5'd0 || q0[N].wd !== {16'd5, 16'h0})
                begin bad++; $display("FAIL wait_first_write: adr=%0d wd=%h exp 0/00050000", q0[N].adr, q0[N].wd); end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_window();
        test_throttle();
        test_done_edge();
        test_wait_ignore();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
